// File: rtl/instr_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory port, core-side queue port and redirect/stop controls.
interface instr_fetch_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] last_pc;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        instr_ready;

    // Fetch unit side
    modport master (
        output mem_req, mem_addr, instr_valid, instr_data, instr_pc,
        input  mem_ack, mem_rdata, last_pc, redirect, redirect_pc, instr_ready
    );

    // Memory / core / control side
    modport slave (
        input  mem_req, mem_addr, instr_valid, instr_data, instr_pc,
        output mem_ack, mem_rdata, last_pc, redirect, redirect_pc, instr_ready
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues word reads, buffers DEPTH {pc,data} entries, hands them to the core.
module instr_fetch #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.master bus_io
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_DISCARD = 2'd2;
    localparam logic [1:0] S_HALT    = 2'd3;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] data;
    } entry_t;

    logic [1:0]       state_q, state_d;
    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]  target_q, target_d;
    logic             target_halt_q, target_halt_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             mem_req_q, mem_req_d;
    logic             valid_q, valid_d;
    entry_t           out_q, out_d;
    entry_t           queue_q [DEPTH];

    logic             acked;
    logic             push;
    logic             pop;
    logic             redir_halt;
    logic [CNT_W-1:0] count_push;
    entry_t           new_entry;

    assign bus_io.mem_req     = mem_req_q;
    assign bus_io.mem_addr    = fetch_pc_q;
    assign bus_io.instr_valid = valid_q;
    assign bus_io.instr_data  = out_q.data;
    assign bus_io.instr_pc    = out_q.pc;

    // Next-state logic: fetch FSM, queue pointers and registered head view
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        target_d      = target_q;
        target_halt_d = target_halt_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        out_d         = out_q;
        push          = 1'b0;
        acked         = mem_req_q & bus_io.mem_ack;
        pop           = valid_q & bus_io.instr_ready & ~bus_io.redirect;
        redir_halt    = bus_io.redirect_pc > bus_io.last_pc;
        count_push    = count_q + CNT_W'(1) - CNT_W'(pop);
        new_entry     = '{pc: fetch_pc_q, data: bus_io.mem_rdata};

        if (bus_io.redirect) begin
            // An unacked request cannot be withdrawn, so its response is discarded first
            if ((state_q == S_WAIT || state_q == S_DISCARD) && !acked) begin
                target_d      = bus_io.redirect_pc;
                target_halt_d = redir_halt;
                state_d       = S_DISCARD;
            end else begin
                fetch_pc_d = bus_io.redirect_pc;
                state_d    = redir_halt ? S_HALT : S_WAIT;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (count_q < CNT_W'(DEPTH)) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (acked) begin
                        push = 1'b1;
                        if (fetch_pc_q == bus_io.last_pc) begin
                            state_d = S_HALT;
                        end else begin
                            fetch_pc_d = fetch_pc_q + XLEN'(1);
                            state_d    = (count_push < CNT_W'(DEPTH)) ? S_WAIT : S_IDLE;
                        end
                    end
                end
                S_DISCARD: begin
                    if (acked) begin
                        fetch_pc_d = target_q;
                        state_d    = target_halt_q ? S_HALT : S_WAIT;
                    end
                end
                default: begin
                end
            endcase
        end

        mem_req_d = (state_d == S_WAIT) || (state_d == S_DISCARD);

        if (bus_io.redirect) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PTR_W'(pop);
            tail_d  = tail_q + PTR_W'(push);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end

        valid_d = (count_d != '0);

        // Head view bypasses the array when the pushed word becomes the head immediately
        if (!bus_io.redirect && valid_d) begin
            out_d = (push && (count_q == CNT_W'(pop))) ? new_entry : queue_q[head_d];
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            fetch_pc_q    <= RESET_PC;
            target_q      <= '0;
            target_halt_q <= 1'b0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            mem_req_q     <= 1'b0;
            valid_q       <= 1'b0;
            out_q         <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            target_q      <= target_d;
            target_halt_q <= target_halt_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            mem_req_q     <= mem_req_d;
            valid_q       <= valid_d;
            out_q         <= out_d;
        end
    end

    // Queue storage write on accepted response
    always_ff @(posedge clk) begin
        if (push) queue_q[tail_q] <= new_entry;
    end
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: streaming, backpressure, redirects, address wrap, mid-request reset.
module tb_instr_fetch;
    localparam logic [31:0] K = 32'hA5A5_0000;

    logic clk;
    logic rst_n;
    logic        ready;
    logic [31:0] last_pc;
    logic        redirect;
    logic [31:0] redirect_pc;
    int          lat;
    int          wcnt;
    int          n_vec;
    int          n_err;

    instr_fetch_if ifa ();
    instr_fetch_if bw ();

    instr_fetch #(.DEPTH(4), .RESET_PC(32'h0)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus_io(ifa)
    );

    instr_fetch #(.DEPTH(4), .RESET_PC(32'hFFFF_FFFE)) u_dut_wrap (
        .clk(clk), .rst_n(rst_n), .bus_io(bw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model for the main DUT: ack after lat extra wait cycles, data = addr ^ K
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) wcnt <= 0;
        else if (ifa.mem_req && !ifa.mem_ack) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end
    assign ifa.mem_ack     = ifa.mem_req && (wcnt >= lat);
    assign ifa.mem_rdata   = ifa.mem_addr ^ K;
    assign ifa.last_pc     = last_pc;
    assign ifa.redirect    = redirect;
    assign ifa.redirect_pc = redirect_pc;
    assign ifa.instr_ready = ready;

    // Zero-wait memory for the wrap-around DUT
    assign bw.mem_ack     = bw.mem_req;
    assign bw.mem_rdata   = bw.mem_addr ^ K;
    assign bw.last_pc     = 32'h1;
    assign bw.redirect    = 1'b0;
    assign bw.redirect_pc = 32'h0;
    assign bw.instr_ready = 1'b1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n    = 1'b0;
        redirect = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; redirect = 1'b0; ready = 1'b1; last_pc = 32'd3; lat = 0;
        step(); step();
        n_vec++;
        if (ifa.mem_req !== 1'b0 || ifa.mem_addr !== 32'h0) begin
            n_err++; $display("FAIL reset_mem: req=%b addr=%h want req=0 addr=0", ifa.mem_req, ifa.mem_addr);
        end
        n_vec++;
        if (ifa.instr_valid !== 1'b0 || ifa.instr_data !== 32'h0 || ifa.instr_pc !== 32'h0) begin
            n_err++; $display("FAIL reset_instr: v=%b d=%h pc=%h want 0/0/0", ifa.instr_valid, ifa.instr_data, ifa.instr_pc);
        end
        n_vec++;
        if (bw.mem_req !== 1'b0 || bw.mem_addr !== 32'hFFFF_FFFE) begin
            n_err++; $display("FAIL reset_wrap_addr: req=%b addr=%h want req=0 addr=fffffffe", bw.mem_req, bw.mem_addr);
        end
    endtask

    task automatic test_stream();
        ready = 1'b1; last_pc = 32'd3; lat = 0;
        apply_reset();
        step();
        n_vec++;
        if (ifa.mem_req !== 1'b1 || ifa.mem_addr !== 32'h0) begin
            n_err++; $display("FAIL first_req: req=%b addr=%h want req=1 addr=0", ifa.mem_req, ifa.mem_addr);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            n_vec++;
            if (ifa.instr_valid !== 1'b1 || ifa.instr_pc !== 32'(i) || ifa.instr_data !== (32'(i) ^ K)) begin
                n_err++; $display("FAIL stream_%0d: v=%b pc=%h d=%h want v=1 pc=%h d=%h",
                    i, ifa.instr_valid, ifa.instr_pc, ifa.instr_data, 32'(i), 32'(i) ^ K);
            end
        end
        n_vec++;
        if (ifa.mem_req !== 1'b0) begin
            n_err++; $display("FAIL stream_halt_req: req=%b want 0", ifa.mem_req);
        end
        step();
        n_vec++;
        if (ifa.instr_valid !== 1'b0) begin
            n_err++; $display("FAIL stream_drain: v=%b want 0", ifa.instr_valid);
        end
        repeat (3) step();
        n_vec++;
        if (ifa.mem_req !== 1'b0) begin
            n_err++; $display("FAIL stream_halt_hold: req=%b want 0", ifa.mem_req);
        end
    endtask

    // Continues from HALT left by test_stream (last_pc = 3)
    task automatic test_redirect_halt();
        redirect = 1'b1; redirect_pc = 32'h50;
        step();
        redirect = 1'b0;
        n_vec++;
        if (ifa.mem_req !== 1'b0 || ifa.instr_valid !== 1'b0) begin
            n_err++; $display("FAIL redir_beyond_last: req=%b v=%b want 0/0", ifa.mem_req, ifa.instr_valid);
        end
        redirect = 1'b1; redirect_pc = 32'h2;
        step();
        redirect = 1'b0;
        n_vec++;
        if (ifa.mem_req !== 1'b1 || ifa.mem_addr !== 32'h2) begin
            n_err++; $display("FAIL redir_from_halt: req=%b addr=%h want 1/2", ifa.mem_req, ifa.mem_addr);
        end
        for (int i = 2; i < 4; i++) begin
            step();
            n_vec++;
            if (ifa.instr_valid !== 1'b1 || ifa.instr_pc !== 32'(i)) begin
                n_err++; $display("FAIL redir_halt_pc_%0d: v=%b pc=%h want 1/%h", i, ifa.instr_valid, ifa.instr_pc, 32'(i));
            end
        end
        n_vec++;
        if (ifa.mem_req !== 1'b0) begin
            n_err++; $display("FAIL redir_rehalt: req=%b want 0", ifa.mem_req);
        end
    endtask

    task automatic test_backpressure();
        int acks;
        ready = 1'b0; last_pc = 32'd100; lat = 0;
        apply_reset();
        acks = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (ifa.mem_req && ifa.mem_ack) acks++;
        end
        n_vec++;
        if (acks !== 4) begin
            n_err++; $display("FAIL full_acks: got %0d want 4", acks);
        end
        n_vec++;
        if (ifa.mem_req !== 1'b0 || ifa.instr_valid !== 1'b1 || ifa.instr_pc !== 32'h0 || ifa.instr_data !== K) begin
            n_err++; $display("FAIL full_state: req=%b v=%b pc=%h d=%h want 0/1/0/%h",
                ifa.mem_req, ifa.instr_valid, ifa.instr_pc, ifa.instr_data, K);
        end
        ready = 1'b1;
        step();
        ready = 1'b0;
        n_vec++;
        if (ifa.instr_pc !== 32'h1 || ifa.instr_data !== (32'h1 ^ K) || ifa.mem_req !== 1'b0) begin
            n_err++; $display("FAIL one_pop: pc=%h d=%h req=%b want 1/%h/0", ifa.instr_pc, ifa.instr_data, ifa.mem_req, 32'h1 ^ K);
        end
        step();
        n_vec++;
        if (ifa.mem_req !== 1'b1 || ifa.mem_addr !== 32'h4) begin
            n_err++; $display("FAIL refill_req: req=%b addr=%h want 1/4", ifa.mem_req, ifa.mem_addr);
        end
        step();
        n_vec++;
        if (ifa.mem_req !== 1'b0 || ifa.instr_valid !== 1'b1 || ifa.instr_pc !== 32'h1) begin
            n_err++; $display("FAIL refill_full: req=%b v=%b pc=%h want 0/1/1", ifa.mem_req, ifa.instr_valid, ifa.instr_pc);
        end
    endtask

    task automatic test_redirect_late_ack();
        logic found, acked, addr_ok, stale, got;
        ready = 1'b1; last_pc = 32'd100; lat = 3;
        apply_reset();
        found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            step();
            if (ifa.mem_req && ifa.mem_addr == 32'h5) found = 1'b1;
        end
        n_vec++;
        if (found !== 1'b1) begin
            n_err++; $display("FAIL late_find_addr5: found=%b want 1", found);
        end
        step();
        redirect = 1'b1; redirect_pc = 32'h40;
        step();
        redirect = 1'b0;
        n_vec++;
        if (ifa.instr_valid !== 1'b0) begin
            n_err++; $display("FAIL late_flush: v=%b want 0", ifa.instr_valid);
        end
        acked = 1'b0; addr_ok = 1'b1; stale = 1'b0;
        for (int i = 0; i < 10 && !acked; i++) begin
            if (!(ifa.mem_req && ifa.mem_addr == 32'h5)) addr_ok = 1'b0;
            if (ifa.instr_valid && ifa.instr_pc == 32'h5) stale = 1'b1;
            if (ifa.mem_ack) acked = 1'b1;
            step();
        end
        n_vec++;
        if (acked !== 1'b1 || addr_ok !== 1'b1) begin
            n_err++; $display("FAIL late_hold_addr: acked=%b addr_held=%b want 1/1", acked, addr_ok);
        end
        n_vec++;
        if (ifa.mem_req !== 1'b1 || ifa.mem_addr !== 32'h40) begin
            n_err++; $display("FAIL late_new_addr: req=%b addr=%h want 1/40", ifa.mem_req, ifa.mem_addr);
        end
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            if (ifa.instr_valid) got = 1'b1;
            else step();
        end
        if (ifa.instr_valid && ifa.instr_pc == 32'h5) stale = 1'b1;
        n_vec++;
        if (got !== 1'b1 || ifa.instr_pc !== 32'h40 || ifa.instr_data !== (32'h40 ^ K)) begin
            n_err++; $display("FAIL late_first_pc: got=%b pc=%h d=%h want 1/40/%h", got, ifa.instr_pc, ifa.instr_data, 32'h40 ^ K);
        end
        n_vec++;
        if (stale !== 1'b0) begin
            n_err++; $display("FAIL late_stale: stale=%b want 0", stale);
        end
        lat = 0;
    endtask

    task automatic test_redirect_ack_pop();
        ready = 1'b1; last_pc = 32'd100; lat = 0;
        apply_reset();
        repeat (4) step();
        n_vec++;
        if (ifa.instr_valid !== 1'b1 || ifa.mem_ack !== 1'b1 || ifa.instr_pc !== 32'h2) begin
            n_err++; $display("FAIL rap_pre: v=%b ack=%b pc=%h want 1/1/2", ifa.instr_valid, ifa.mem_ack, ifa.instr_pc);
        end
        redirect = 1'b1; redirect_pc = 32'h10;
        step();
        redirect = 1'b0;
        n_vec++;
        if (ifa.instr_valid !== 1'b0 || ifa.mem_req !== 1'b1 || ifa.mem_addr !== 32'h10) begin
            n_err++; $display("FAIL rap_flush: v=%b req=%b addr=%h want 0/1/10", ifa.instr_valid, ifa.mem_req, ifa.mem_addr);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_vec++;
            if (ifa.instr_valid !== 1'b1 || ifa.instr_pc !== (32'h10 + 32'(i)) || ifa.instr_data !== ((32'h10 + 32'(i)) ^ K)) begin
                n_err++; $display("FAIL rap_seq_%0d: v=%b pc=%h d=%h want 1/%h", i, ifa.instr_valid, ifa.instr_pc,
                    ifa.instr_data, 32'h10 + 32'(i));
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc [4];
        exp_pc = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
        apply_reset();
        step();
        n_vec++;
        if (bw.mem_req !== 1'b1 || bw.mem_addr !== 32'hFFFF_FFFE) begin
            n_err++; $display("FAIL wrap_first_req: req=%b addr=%h want 1/fffffffe", bw.mem_req, bw.mem_addr);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            n_vec++;
            if (bw.instr_valid !== 1'b1 || bw.instr_pc !== exp_pc[i] || bw.instr_data !== (exp_pc[i] ^ K)) begin
                n_err++; $display("FAIL wrap_pc_%0d: v=%b pc=%h d=%h want 1/%h/%h", i, bw.instr_valid, bw.instr_pc,
                    bw.instr_data, exp_pc[i], exp_pc[i] ^ K);
            end
        end
        n_vec++;
        if (bw.mem_req !== 1'b0) begin
            n_err++; $display("FAIL wrap_halt: req=%b want 0", bw.mem_req);
        end
    endtask

    task automatic test_reset_mid();
        ready = 1'b0; last_pc = 32'd100; lat = 0;
        apply_reset();
        repeat (3) step();
        n_vec++;
        if (ifa.instr_valid !== 1'b1 || ifa.mem_req !== 1'b1 || ifa.mem_addr !== 32'h2) begin
            n_err++; $display("FAIL rmid_pre: v=%b req=%b addr=%h want 1/1/2", ifa.instr_valid, ifa.mem_req, ifa.mem_addr);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (ifa.mem_req !== 1'b0 || ifa.instr_valid !== 1'b0) begin
            n_err++; $display("FAIL rmid_async: req=%b v=%b want 0/0", ifa.mem_req, ifa.instr_valid);
        end
        step();
        rst_n = 1'b1;
        step();
        n_vec++;
        if (ifa.mem_req !== 1'b1 || ifa.mem_addr !== 32'h0 || ifa.instr_valid !== 1'b0) begin
            n_err++; $display("FAIL rmid_restart: req=%b addr=%h v=%b want 1/0/0", ifa.mem_req, ifa.mem_addr, ifa.instr_valid);
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst_n = 1'b0; ready = 1'b0; last_pc = 32'd3; redirect = 1'b0; redirect_pc = 32'h0; lat = 0;
        test_reset();
        test_stream();
        test_redirect_halt();
        test_backpressure();
        test_redirect_late_ack();
        test_redirect_ack_pop();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
